// File: rtl/verificador_funcion.sv
// Sequences all eight {a,b,c} vectors into a combinational function and compares z against EXPECTED.
// Optional STOP_ON_FAIL_EN: abort the sweep at the first mismatching vector.
//
// state | meaning
// IDLE  | waiting for start; results and last vector held
// APPLY | vector on {a,b,c}, settle counter running, z sampled when it reaches 0
// DONE  | one-cycle done pulse, results final
module verificador_funcion #(
    parameter logic [7:0]  EXPECTED = 8'h5C,
    parameter int unsigned SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       z,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] observed,
    output logic [3:0] fail_cnt,
    output logic [2:0] fail_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
    localparam logic [3:0] FAIL_MAX  = 4'd8;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] settle_q, settle_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] observed_q, observed_d;
    logic [3:0] fail_cnt_q, fail_cnt_d;
    logic [2:0] fail_idx_q, fail_idx_d;

    logic       mismatch;
    logic       stop;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settle_d   = settle_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        observed_d = observed_q;
        fail_cnt_d = fail_cnt_q;
        fail_idx_d = fail_idx_q;
        mismatch   = 1'b0;
        stop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d      = 3'd0;
                    observed_d = 8'h00;
                    fail_cnt_d = 4'd0;
                    fail_idx_d = 3'd0;
                    pass_d     = 1'b0;
                    settle_d   = SETTLE_LD;
                    busy_d     = 1'b1;
                    state_d    = APPLY;
                end
            end

            APPLY: begin
                if (settle_q != 4'd0) begin
                    settle_d = settle_q - 4'd1;
                end else begin
                    observed_d[idx_q] = z;
                    mismatch          = (z != EXPECTED[idx_q]);
                    if (mismatch) begin
                        if (fail_cnt_q == 4'd0) begin
                            fail_idx_d = idx_q;
                        end
                        if (fail_cnt_q != FAIL_MAX) begin
                            fail_cnt_d = fail_cnt_q + 4'd1;
                        end
                    end
                    stop = (idx_q == 3'd7);
`ifdef STOP_ON_FAIL_EN
                    if (mismatch) begin
                        stop = 1'b1;
                    end
`endif
                    if (stop) begin
                        // pass is resolved from the updated count so it is valid alongside done
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (fail_cnt_d == 4'd0);
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        settle_d = SETTLE_LD;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            settle_q   <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            observed_q <= 8'h00;
            fail_cnt_q <= 4'd0;
            fail_idx_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            settle_q   <= settle_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            observed_q <= observed_d;
            fail_cnt_q <= fail_cnt_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    // the index register is the applied vector, index = {a,b,c}
    assign a        = idx_q[2];
    assign b        = idx_q[1];
    assign c        = idx_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign observed = observed_q;
    assign fail_cnt = fail_cnt_q;
    assign fail_idx = fail_idx_q;

endmodule

// File: doc/verificador_funcion.md
VERIFICADOR_FUNCION -- requirements
Module: verificador_funcion

Interface
REQ-001 SHALL have parameter EXPECTED, default 8'h5C: golden truth table, bit i = required z for input index i = {a,b,c}.
REQ-002 SHALL have parameter SETTLE, default 2, range 0..15: extra clock cycles each vector is held before z is sampled.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-006 SHALL have port z, input, 1 bit: response of the combinational function under test.
REQ-007 SHALL have ports a, b, c, output, 1 bit each, registered: stimulus driven to the function under test.
REQ-008 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a sweep.
REQ-010 SHALL have port pass, output, 1 bit: high when observed equals EXPECTED.
REQ-011 SHALL have port observed, output, 8 bits: captured truth table.
REQ-012 SHALL have port fail_cnt, output, 4 bits: number of mismatching vectors.
REQ-013 SHALL have port fail_idx, output, 3 bits: lowest mismatching index.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, DONE.
REQ-015 IDLE with start=1 at edge E0 SHALL: set {a,b,c}=3'b000, clear observed/fail_cnt/fail_idx/pass, load the settle counter with SETTLE, assert busy, and go to APPLY.
REQ-016 In APPLY, each vector SHALL be held on {a,b,c} for exactly SETTLE+1 cycles; z SHALL be sampled into observed[index] on the last edge of that window.
REQ-017 On the sampling edge, if index<7, index SHALL increment and the new vector SHALL be driven on the same edge.
REQ-018 On the sampling edge, if index==7, the FSM SHALL go to DONE; a full sweep SHALL assert done on edge E0+8*(SETTLE+1).
REQ-019 Mismatch is z!=EXPECTED[index] at the sampling edge.
REQ-020 On a mismatch, fail_cnt SHALL increment (saturating at 8); fail_idx SHALL latch index only on the first mismatch.
REQ-021 In DONE, done=1 and busy=0 for exactly one cycle.
REQ-022 DONE SHALL set pass=1 iff fail_cnt==0, then return to IDLE.
REQ-023 pass, observed, fail_cnt and fail_idx SHALL hold until the next accepted start.
REQ-024 {a,b,c} SHALL hold the last applied vector in IDLE.
REQ-025 start while busy or in DONE SHALL be ignored; no queuing.
REQ-026 start held high continuously SHALL re-launch a sweep on the cycle after done.
REQ-027 SETTLE=0 SHALL give one cycle per vector, with done at E0+8.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, a=b=c=0, busy=0, done=0, pass=0, observed=0, fail_cnt=0, fail_idx=0, and index and settle counter to 0, regardless of clk.
REQ-029 Reset mid-sweep SHALL abort the sweep with no done pulse; the first start after release SHALL begin a fresh sweep at index 0.

Configuration
REQ-030 Macro STOP_ON_FAIL_EN defined: the first mismatch SHALL record its bit, set fail_cnt=1 and fail_idx=index, and go directly to DONE; unswept observed bits SHALL remain 0.
REQ-031 Macro STOP_ON_FAIL_EN undefined: all 8 vectors SHALL always be swept per REQ-016 to REQ-022.

Verification
REQ-032 Behavioural model of the function under test on z, SETTLE=2, start pulse -> done at E0+24, observed=8'h5C, pass=1, fail_cnt=0.
REQ-033 z tied 0 -> observed=8'h00, fail_cnt=4, fail_idx=2, pass=0.
REQ-034 z = inverted model -> observed=8'hA3, fail_cnt=8, fail_idx=0, pass=0.
REQ-035 rst_n pulsed low during index 4, then start -> no done from the aborted sweep; the new sweep yields pass=1 at E0'+24.
REQ-036 start re-pulsed while busy -> exactly one done, at the original E0+24.
REQ-037 STOP_ON_FAIL_EN with z tied 0 -> done at E0+9, fail_idx=2, fail_cnt=1, observed=8'h00.
